// File: rtl/imem_read_responder_if.sv
// Instruction-memory read handshake plus program-load write port, shared by the
// fetch-side requester (master) and the memory responder (slave).
interface imem_read_responder_if #(
   parameter int XLEN           = 32,
   parameter int READ_ADDR_SIZE = 32
);
   // Read handshake: the requester raises mem_readEn with mem_read_addr; the
   // request is taken on an edge where the responder is not busy (IDLE or DONE).
   // mem_readEn while busy is dropped, so the requester must hold or re-issue it.
   // readFin pulses for one cycle with mem_read_data (and misalign_err) valid.
   logic                      mem_readEn;
   logic [READ_ADDR_SIZE-1:0] mem_read_addr;
   logic [XLEN-1:0]           mem_read_data;
   logic                      readFin;
   logic                      misalign_err;
   logic                      busy;

   logic                      load_en;
   logic [READ_ADDR_SIZE-1:0] load_addr;
   logic [XLEN-1:0]           load_data;

   modport master (
      output mem_readEn, mem_read_addr, load_en, load_addr, load_data,
      input  mem_read_data, readFin, misalign_err, busy
   );

   modport slave (
      input  mem_readEn, mem_read_addr, load_en, load_addr, load_data,
      output mem_read_data, readFin, misalign_err, busy
   );
endinterface

// File: rtl/imem_read_responder.sv
// Fixed-latency instruction-memory responder backed by a word-addressed RAM.
// Optional IMEM_RESP_STATS_EN adds a read_count output counting completions.
module imem_read_responder #(
   parameter int XLEN           = 32,
   parameter int READ_ADDR_SIZE = 32,
   parameter int DEPTH_LOG2     = 10,
   parameter int READ_LATENCY   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_read_responder_if.slave  bus,
   output logic [1:0]            dbg_state
`ifdef IMEM_RESP_STATS_EN
   ,
   output logic [31:0]           read_count
`endif
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
      $error("imem_read_responder: READ_LATENCY must be within 1..15");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic [3:0]            lat_cnt;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  rd_misalign;
   logic [XLEN-1:0]       rd_data_q;
   logic                  fin_q;
   logic                  err_q;

   logic [XLEN-1:0]       mem [DEPTH];

   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req_misalign;
   logic [DEPTH_LOG2-1:0] ld_idx;

   // Upper address bits wrap modulo DEPTH; load byte offset is ignored.
   assign req_idx      = bus.mem_read_addr[DEPTH_LOG2+1:2];
   assign req_misalign = |bus.mem_read_addr[1:0];
   assign ld_idx       = bus.load_addr[DEPTH_LOG2+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.mem_read_addr[READ_ADDR_SIZE-1:DEPTH_LOG2+2],
                               bus.load_addr[READ_ADDR_SIZE-1:DEPTH_LOG2+2],
                               bus.load_addr[1:0]};

   // Loader port has no reset so boot logic can fill memory while rst is held.
   always_ff @(posedge clk) begin
      if (bus.load_en) begin
         mem[ld_idx] <= bus.load_data;
      end
   end

   // Array is sampled on the edge entering DONE, so a load on that same edge
   // lands after the read and the old word is returned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         rd_idx      <= '0;
         rd_misalign <= 1'b0;
         rd_data_q   <= '0;
         fin_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         fin_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.mem_readEn) begin
                  rd_idx      <= req_idx;
                  rd_misalign <= req_misalign;
                  lat_cnt     <= LAT_INIT;
                  state       <= BUSY;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               if (lat_cnt == 4'd0) begin
                  state     <= DONE;
                  fin_q     <= 1'b1;
                  err_q     <= rd_misalign;
                  rd_data_q <= rd_misalign ? '0 : mem[rd_idx];
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_read_data = rd_data_q;
   assign bus.readFin       = fin_q;
   assign bus.misalign_err  = err_q;
   assign bus.busy          = (state == BUSY);
   assign dbg_state         = state;

`ifdef IMEM_RESP_STATS_EN
   // Bumps on the same edge that raises readFin.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_count <= '0;
      end else if (state == BUSY && lat_cnt == 4'd0) begin
         read_count <= read_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_read_responder.sv
// Directed bench for imem_read_responder (READ_LATENCY=2, DEPTH_LOG2=10).
// Define IMEM_RESP_STATS_EN to also cover read_count.
module tb_imem_read_responder;

   logic clk;
   logic rst;
   logic [1:0] dbg_state;
`ifdef IMEM_RESP_STATS_EN
   logic [31:0] read_count;
`endif

   int checks;
   int failures;

   imem_read_responder_if #(.XLEN(32), .READ_ADDR_SIZE(32)) bus ();

   imem_read_responder #(
      .XLEN(32),
      .READ_ADDR_SIZE(32),
      .DEPTH_LOG2(10),
      .READ_LATENCY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .dbg_state(dbg_state)
`ifdef IMEM_RESP_STATS_EN
      ,
      .read_count(read_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // driver tasks: inputs change 1 time unit after a rising edge, outputs are
   // sampled at the same point
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      step();
      bus.load_en   = 1'b0;
   endtask

   task automatic start_read(input logic [31:0] addr);
      bus.mem_readEn    = 1'b1;
      bus.mem_read_addr = addr;
      step();
      bus.mem_readEn    = 1'b0;
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      rst               = 1'b1;
      bus.mem_readEn    = 1'b0;
      bus.mem_read_addr = '0;
      bus.load_en       = 1'b0;
      bus.load_addr     = '0;
      bus.load_data     = '0;
      step();
      step();
      check("rst_fin",   32'(bus.readFin), 32'd0);
      check("rst_data",  bus.mem_read_data, 32'd0);
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_err",   32'(bus.misalign_err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      step();

      // single read, latency 2
      do_load(32'h0, 32'h0000_0013);
      start_read(32'h0);
      check("t1_busy", 32'(bus.busy), 32'd1);
      check("t1_fin_n0", 32'(bus.readFin), 32'd0);
      step();
      check("t1_fin_n1", 32'(bus.readFin), 32'd0);
      step();
      check("t1_fin", 32'(bus.readFin), 32'd1);
      check("t1_data", bus.mem_read_data, 32'h0000_0013);
      check("t1_err", 32'(bus.misalign_err), 32'd0);
      check("t1_state_done", 32'(dbg_state), 32'd2);
      step();
      check("t1_fin_drop", 32'(bus.readFin), 32'd0);
      check("t1_data_hold", bus.mem_read_data, 32'h0000_0013);
      check("t1_idle", 32'(dbg_state), 32'd0);

      // back-to-back reads; address change during BUSY is ignored
      do_load(32'h4, 32'h1111_1111);
      do_load(32'h8, 32'h2222_2222);
      bus.mem_readEn    = 1'b1;
      bus.mem_read_addr = 32'h4;
      step();
      bus.mem_read_addr = 32'h8;
      step();
      check("t2_fin_mid", 32'(bus.readFin), 32'd0);
      step();
      check("t2_fin_a", 32'(bus.readFin), 32'd1);
      check("t2_data_a", bus.mem_read_data, 32'h1111_1111);
      step();
      bus.mem_readEn = 1'b0;
      check("t2_gap_fin", 32'(bus.readFin), 32'd0);
      check("t2_gap_busy", 32'(bus.busy), 32'd1);
      step();
      check("t2_gap2_fin", 32'(bus.readFin), 32'd0);
      step();
      check("t2_fin_b", 32'(bus.readFin), 32'd1);
      check("t2_data_b", bus.mem_read_data, 32'h2222_2222);
      step();

      // misaligned read
      start_read(32'h6);
      step();
      step();
      check("t3_fin", 32'(bus.readFin), 32'd1);
      check("t3_data", bus.mem_read_data, 32'd0);
      check("t3_err", 32'(bus.misalign_err), 32'd1);
      step();
      check("t3_err_drop", 32'(bus.misalign_err), 32'd0);

      // address wrap modulo 1024 words
      do_load(32'h0, 32'hDEAD_BEEF);
      start_read(32'h1000);
      step();
      step();
      check("t4_fin", 32'(bus.readFin), 32'd1);
      check("t4_data", bus.mem_read_data, 32'hDEAD_BEEF);
      step();

      // load on the edge entering DONE is not visible to that read
      do_load(32'h10, 32'hAAAA_0000);
      start_read(32'h10);
      step();
      bus.load_en   = 1'b1;
      bus.load_addr = 32'h10;
      bus.load_data = 32'hBBBB_0000;
      step();
      bus.load_en   = 1'b0;
      check("t5_fin_old", 32'(bus.readFin), 32'd1);
      check("t5_data_old", bus.mem_read_data, 32'hAAAA_0000);
      step();
      start_read(32'h10);
      step();
      step();
      check("t5_fin_new", 32'(bus.readFin), 32'd1);
      check("t5_data_new", bus.mem_read_data, 32'hBBBB_0000);
      step();
`ifdef IMEM_RESP_STATS_EN
      check("stats_count7", read_count, 32'd7);
`endif

      // reset mid-read aborts it; load during reset still lands
      start_read(32'h0);
      rst           = 1'b1;
      bus.load_en   = 1'b1;
      bus.load_addr = 32'h20;
      bus.load_data = 32'h5555_5555;
      step();
      rst         = 1'b0;
      bus.load_en = 1'b0;
      check("t6_fin", 32'(bus.readFin), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_data", bus.mem_read_data, 32'd0);
      check("t6_state", 32'(dbg_state), 32'd0);
`ifdef IMEM_RESP_STATS_EN
      check("t6_count0", read_count, 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_no_fin", 32'(bus.readFin), 32'd0);
      end
      start_read(32'h20);
      step();
      step();
      check("t6_fin_after", 32'(bus.readFin), 32'd1);
      check("t6_data_after", bus.mem_read_data, 32'h5555_5555);
      step();
`ifdef IMEM_RESP_STATS_EN
      check("t6_count1", read_count, 32'd1);
`endif

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
